// File: rtl/ser2par8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ser2par8_pkg
//  Description : Shared state encodings, parameter defaults and helpers for
//                the ser2par8 serial-to-parallel word assembler.
//  Revision    : 1.0 - initial release
// ============================================================================
package ser2par8_pkg;

  localparam int WIDTH_DEFAULT     = 8;
  localparam int MSB_FIRST_DEFAULT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : bit_cnt
//  Description : Received-bit counter with synchronous clear, enable and a
//                terminal-count flag that marks the final bit of a word.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_cnt #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and saturate at WIDTH.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CW'(WIDTH))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register, asynchronously cleared.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The next enabled edge carries the last bit of the word.
  assign tc = (cnt_q == CW'(WIDTH - 1));

endmodule
`default_nettype wire

// File: rtl/ser2par8.sv
`default_nettype none
// ============================================================================
//  Module      : ser2par8
//  Description : Serial-to-parallel word assembler. A start request opens a
//                WIDTH-bit shift window; the finished word is presented on
//                data_out with Oen held until the consumer acknowledges.
//  Revision    : 1.0 - initial release
// ============================================================================
module ser2par8
  import ser2par8_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter int MSB_FIRST = MSB_FIRST_DEFAULT
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ser_in,
  input  logic             start,
  input  logic             abort,
  input  logic             ack,
  output logic [WIDTH-1:0] data_out,
  output logic             Oen,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q,  sreg_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             oen_q,   oen_d;
  logic             busy_q,  busy_d;
  logic [WIDTH-1:0] shift_nxt;
  logic             cnt_clear;
  logic             cnt_en;
  logic             last_bit;

  // Bit order: first-received bit ends up at the MSB or at the LSB.
  if (MSB_FIRST != 0) begin : g_msb_first
    assign shift_nxt = {sreg_q[WIDTH-2:0], ser_in};
  end else begin : g_lsb_first
    assign shift_nxt = {ser_in, sreg_q[WIDTH-1:1]};
  end

  bit_cnt #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_cnt (
    .clk   (clk),
    .clr   (clr),
    .clear (cnt_clear),
    .en    (cnt_en),
    .tc    (last_bit)
  );

  // Next-state and datapath decisions; abort outranks the final-bit load.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    data_d    = data_q;
    oen_d     = oen_q;
    busy_d    = busy_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SHIFT;
          busy_d    = 1'b1;
          cnt_clear = 1'b1;
          sreg_d    = '0;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          cnt_clear = 1'b1;
          sreg_d    = '0;
        end else begin
          cnt_en = 1'b1;
          sreg_d = shift_nxt;
          if (last_bit) begin
            data_d  = shift_nxt;
            state_d = ST_DONE;
            oen_d   = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      ST_DONE: begin
        if (ack) begin
          oen_d     = 1'b0;
          cnt_clear = 1'b1;
          if (start) begin
            state_d = ST_SHIFT;
            busy_d  = 1'b1;
            sreg_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        oen_d     = 1'b0;
        busy_d    = 1'b0;
        cnt_clear = 1'b1;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      data_q  <= '0;
      oen_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      data_q  <= data_d;
      oen_q   <= oen_d;
      busy_q  <= busy_d;
    end
  end

  assign data_out = data_q;
  assign Oen      = oen_q;
  assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ser2par8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ser2par8
//  Description : Self-checking bench for ser2par8; drives an MSB-first and an
//                LSB-first instance with the same stimulus and compares both
//                against a word-level reference model every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ser2par8;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         ser_in = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         ack = 1'b0;
  logic [W-1:0] data_m, data_l;
  logic         oen_m, oen_l, busy_m, busy_l;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ser2par8 #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .clr(clr), .ser_in(ser_in), .start(start), .abort(abort),
    .ack(ack), .data_out(data_m), .Oen(oen_m), .busy(busy_m)
  );

  ser2par8 #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .clr(clr), .ser_in(ser_in), .start(start), .abort(abort),
    .ack(ack), .data_out(data_l), .Oen(oen_l), .busy(busy_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  // Reference model: counts bits of the open word as an integer stream value.
  logic         m_busy, m_oen;
  logic [W-1:0] m_dm, m_dl;
  int           m_n, m_acc;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_busy <= 1'b0; m_oen <= 1'b0; m_dm <= '0; m_dl <= '0; m_n <= 0; m_acc <= 0;
    end else if (m_busy) begin
      if (abort) begin
        m_busy <= 1'b0; m_n <= 0; m_acc <= 0;
      end else if (m_n == W - 1) begin
        m_dm   <= W'(m_acc * 2 + int'(ser_in));
        m_dl   <= rev(W'(m_acc * 2 + int'(ser_in)));
        m_oen  <= 1'b1;
        m_busy <= 1'b0;
        m_n    <= 0;
        m_acc  <= 0;
      end else begin
        m_acc <= m_acc * 2 + int'(ser_in);
        m_n   <= m_n + 1;
      end
    end else if (m_oen) begin
      if (ack) begin
        m_oen  <= 1'b0;
        m_busy <= start;
      end
    end else if (start) begin
      m_busy <= 1'b1;
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_data_msb", 32'(data_m), 32'(m_dm));
    chk("cyc_data_lsb", 32'(data_l), 32'(m_dl));
    chk("cyc_oen_msb",  32'(oen_m),  32'(m_oen));
    chk("cyc_oen_lsb",  32'(oen_l),  32'(m_oen));
    chk("cyc_busy_msb", 32'(busy_m), 32'(m_busy));
    chk("cyc_busy_lsb", 32'(busy_l), 32'(m_busy));
  end

  // One clock edge with the given inputs; returns 1 time unit after the edge.
  task automatic drive(input logic s, input logic b, input logic a, input logic k);
    start = s; ser_in = b; abort = a; ack = k;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int n, input logic st);
    for (int i = 0; i < n; i++) drive(st, w[W-1-i], 1'b0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] word;
    int           rises;
    logic         prev;

    #1 clr = 1'b0;
    #1;
    chk("rst_data", 32'(data_m), 32'h0);
    chk("rst_oen",  32'(oen_m),  32'h0);
    chk("rst_busy", 32'(busy_m), 32'h0);
    @(negedge clk);
    clr = 1'b1;

    // Test 1/2: stream A6 into both bit orders, latency WIDTH+1.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_busy_after_start", 32'(busy_m), 32'h1);
    word = 8'hA6;
    for (int i = 0; i < W; i++) begin
      drive(1'b0, word[W-1-i], 1'b0, 1'b0);
      if (i < W - 1) chk("t1_oen_low_in_shift", 32'(oen_m), 32'h0);
    end
    chk("t1_oen", 32'(oen_m), 32'h1);
    chk("t1_data_msb", 32'(data_m), 32'hA6);
    chk("t2_data_lsb", 32'(data_l), 32'h65);
    chk("t1_busy_done", 32'(busy_m), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_oen_held", 32'(oen_m), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1_oen_after_ack", 32'(oen_m), 32'h0);

    // Test 3: abort after four bits keeps the previous word.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(8'hF0, 4, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t3_busy", 32'(busy_m), 32'h0);
    chk("t3_oen",  32'(oen_m),  32'h0);
    chk("t3_data", 32'(data_m), 32'hA6);

    // Test 4: ack+start together in DONE, then FF with no idle gap.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(8'hA6, W, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t4_busy_direct", 32'(busy_m), 32'h1);
    chk("t4_oen_dropped", 32'(oen_m), 32'h0);
    for (int i = 0; i < W; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      if (i < W - 1) chk("t4_oen_low", 32'(oen_m), 32'h0);
    end
    chk("t4_oen", 32'(oen_m), 32'h1);
    chk("t4_data", 32'(data_m), 32'hFF);
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // Test 6: start held during SHIFT and pending DONE.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    word  = 8'h3C;
    rises = 0;
    prev  = oen_m;
    for (int i = 0; i < W + 2; i++) begin
      drive(1'b1, (i < W) ? word[W-1-i] : 1'b0, 1'b0, 1'b0);
      if (oen_m && !prev) rises++;
      prev = oen_m;
    end
    chk("t6_done_entries", 32'(rises), 32'h1);
    chk("t6_data", 32'(data_m), 32'h3C);
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // Abort on the final-bit edge wins over the load.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(8'h00, W - 1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    chk("abort_last_oen",  32'(oen_m),  32'h0);
    chk("abort_last_data", 32'(data_m), 32'h3C);
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // Test 5: asynchronous clear mid-SHIFT, then mid-DONE.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(8'hE0, 3, 1'b0);
    #1 clr = 1'b0;
    #1;
    chk("t5_shift_data", 32'(data_m), 32'h0);
    chk("t5_shift_oen",  32'(oen_m),  32'h0);
    chk("t5_shift_busy", 32'(busy_m), 32'h0);
    #1 clr = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_start_after_release", 32'(busy_m), 32'h1);
    send_bits(8'h5A, W, 1'b0);
    chk("t5_done_data", 32'(data_m), 32'h5A);
    #1 clr = 1'b0;
    #1;
    chk("t5_done_data_clr", 32'(data_m), 32'h0);
    chk("t5_done_oen_clr",  32'(oen_m),  32'h0);
    chk("t5_done_busy_clr", 32'(busy_m), 32'h0);
    #1 clr = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    chk("t5_needs_start", 32'(busy_m | oen_m), 32'h0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
